// File: rtl/div_meter_pkg.sv
// Shared types and default sizing for the divider-ratio monitors.
package div_meter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } meter_state_t;

  localparam int DM_CNT_W  = 8;
  localparam int DM_LOCK_N = 4;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector for a signal already synchronous to clk_in.
module rise_det (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise
);

  logic sig_q;

  // Previous sample of sig_in.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_in;
    end
  end

  assign rise = sig_in & ~sig_q;

endmodule

// File: rtl/div_ratio_meter.sv
// Measures period and high time of a divided clock in clk_in cycles and
// flags lock once LOCK_N consecutive measurements agree.
module div_ratio_meter
  import div_meter_pkg::*;
#(
  parameter int CNT_W  = DM_CNT_W,
  parameter int LOCK_N = DM_LOCK_N
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             overflow
);

  localparam int                 MATCH_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(LOCK_N);

  meter_state_t       state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   hi_cnt_r;
  logic [MATCH_W-1:0] match_r;
  logic [MATCH_W-1:0] next_match_s;
  logic               same_s;
  logic               rise_s;

  rise_det u_rise_det (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise_s)
  );

  // Match count that would result if the current window closed this cycle.
  always_comb begin
    same_s = (cnt_r == period) && (hi_cnt_r == high_time);
    if (!same_s) begin
      next_match_s = MATCH_W'(1);
    end else if (match_r == MATCH_FULL) begin
      next_match_s = match_r;
    end else begin
      next_match_s = match_r + MATCH_W'(1);
    end
  end

  // Measurement FSM, counters, lock tracker and output registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      hi_cnt_r  <= '0;
      match_r   <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        // Disable beats any concurrent edge; results and overflow are kept.
        state_r  <= IDLE;
        cnt_r    <= '0;
        hi_cnt_r <= '0;
        match_r  <= '0;
        locked   <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= WAIT_EDGE;
          end
          WAIT_EDGE: begin
            if (rise_s) begin
              cnt_r    <= CNT_W'(1);
              hi_cnt_r <= CNT_W'(1);
              state_r  <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise_s) begin
              period    <= cnt_r;
              high_time <= hi_cnt_r;
              valid     <= 1'b1;
              overflow  <= 1'b0;
              cnt_r     <= CNT_W'(1);
              hi_cnt_r  <= CNT_W'(1);
              match_r   <= next_match_s;
              locked    <= (next_match_s == MATCH_FULL);
            end else if (cnt_r == CNT_MAX) begin
              overflow <= 1'b1;
              locked   <= 1'b0;
              match_r  <= '0;
              cnt_r    <= '0;
              hi_cnt_r <= '0;
              state_r  <= WAIT_EDGE;
            end else begin
              cnt_r    <= cnt_r + CNT_W'(1);
              hi_cnt_r <= hi_cnt_r + CNT_W'(sig_in);
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed bench for div_ratio_meter: table of steady divider patterns plus
// hand-written lock-loss, overflow, enable and reset sequences.
module tb_div_ratio_meter;
  import div_meter_pkg::*;

  logic       clk_in;
  logic       rst_n;
  logic       en;
  logic       sig_in;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       valid;
  logic       locked;
  logic       overflow;

  int total;
  int bad;
  int cyc;

  typedef struct {
    string      name;
    logic [7:0] pat;
    int         plen;
    int         exp_period;
    int         exp_high;
  } vec_t;

  typedef struct {
    int   cyc;
    int   per;
    int   hi;
    logic lk;
    int   mt;
  } vrec_t;

  vec_t  vecs[5];
  vrec_t recs[$];

  div_ratio_meter #(.CNT_W(8), .LOCK_N(4)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .overflow  (overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // One clock: inputs already set; outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    en     = 1'b0;
    sig_in = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    en    = 1'b1;
  endtask

  task automatic run_pat(input logic [7:0] pat, input int plen, input int reps);
    vrec_t r;
    for (int rp = 0; rp < reps; rp++) begin
      for (int i = 0; i < plen; i++) begin
        sig_in = pat[i];
        step();
        if (valid) begin
          r.cyc = cyc;
          r.per = int'(period);
          r.hi  = int'(high_time);
          r.lk  = locked;
          r.mt  = int'(dut.match_r);
          recs.push_back(r);
        end
      end
    end
  endtask

  initial begin
    int first_ov;
    int nvalid;
    logic lk_at_ov;
    int st_at_ov;

    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    sig_in = 1'b0;

    vecs[0] = '{"div2",  8'b0000_0001, 2, 2, 1};
    vecs[1] = '{"div4",  8'b0000_0011, 4, 4, 2};
    vecs[2] = '{"div3a", 8'b0000_0011, 3, 3, 2};
    vecs[3] = '{"div3b", 8'b0000_0001, 3, 3, 1};
    vecs[4] = '{"div8",  8'b0000_0111, 8, 8, 3};

    // Reset state
    step();
    step();
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Steady patterns: first edge is lost in IDLE, second opens the window.
    for (int v = 0; v < 5; v++) begin
      reset_dut();
      recs.delete();
      run_pat(vecs[v].pat, vecs[v].plen, 10);
      chk({vecs[v].name, "_nvalid"}, recs.size(), 8);
      for (int k = 0; k < recs.size(); k++) begin
        chk({vecs[v].name, "_period"}, recs[k].per, vecs[v].exp_period);
        chk({vecs[v].name, "_high"}, recs[k].hi, vecs[v].exp_high);
        chk({vecs[v].name, "_locked"}, int'(recs[k].lk), (k >= 3) ? 1 : 0);
        if (k > 0)
          chk({vecs[v].name, "_spacing"}, recs[k].cyc - recs[k-1].cyc, vecs[v].exp_period);
      end
    end

    // 3x 1,1,0 locked, then switch to 1,0,0: lock drops, match restarts at 1.
    reset_dut();
    recs.delete();
    run_pat(8'b0000_0011, 3, 8);
    chk("sw_pre_locked", int'(locked), 1);
    recs.delete();
    run_pat(8'b0000_0001, 3, 6);
    chk("sw_nvalid", recs.size(), 6);
    chk("sw_v0_high", recs[0].hi, 2);
    chk("sw_v0_locked", int'(recs[0].lk), 1);
    chk("sw_v1_high", recs[1].hi, 1);
    chk("sw_v1_period", recs[1].per, 3);
    chk("sw_v1_locked", int'(recs[1].lk), 0);
    chk("sw_v1_match", recs[1].mt, 1);
    chk("sw_v3_locked", int'(recs[3].lk), 0);
    chk("sw_v4_locked", int'(recs[4].lk), 1);

    // Overflow: lock on 2x, then hold low.
    reset_dut();
    recs.delete();
    run_pat(8'b0000_0001, 2, 8);
    chk("ov_pre_locked", int'(locked), 1);
    first_ov = -1;
    nvalid   = 0;
    lk_at_ov = 1'b1;
    st_at_ov = -1;
    for (int k = 1; k <= 300; k++) begin
      sig_in = 1'b0;
      step();
      if (valid) nvalid++;
      if (overflow && first_ov < 0) begin
        first_ov = k;
        lk_at_ov = locked;
        st_at_ov = int'(dut.state_r);
      end
    end
    chk("ov_first_step", first_ov, 254);
    chk("ov_locked", int'(lk_at_ov), 0);
    chk("ov_state", st_at_ov, int'(WAIT_EDGE));
    chk("ov_no_valid", nvalid, 0);
    sig_in = 1'b1;
    step();
    chk("ov_open_valid", int'(valid), 0);
    chk("ov_still_set", int'(overflow), 1);
    for (int k = 0; k < 3; k++) begin
      sig_in = 1'b0;
      step();
    end
    sig_in = 1'b1;
    step();
    chk("ov_rec_valid", int'(valid), 1);
    chk("ov_rec_period", int'(period), 4);
    chk("ov_rec_high", int'(high_time), 1);
    chk("ov_rec_clear", int'(overflow), 0);

    // Rise exactly at counter maximum gives a measurement, not overflow.
    for (int k = 0; k < 254; k++) begin
      sig_in = 1'b0;
      step();
    end
    sig_in = 1'b1;
    step();
    chk("max_valid", int'(valid), 1);
    chk("max_period", int'(period), 255);
    chk("max_high", int'(high_time), 1);
    chk("max_overflow", int'(overflow), 0);

    // Disable coinciding with a rise.
    reset_dut();
    recs.delete();
    run_pat(8'b0000_0001, 2, 8);
    chk("en_pre_locked", int'(locked), 1);
    for (int k = 0; k < 3; k++) begin
      sig_in = 1'b0;
      step();
    end
    sig_in = 1'b1;
    en     = 1'b0;
    step();
    chk("en_drop_valid", int'(valid), 0);
    chk("en_drop_locked", int'(locked), 0);
    chk("en_drop_period", int'(period), 2);

    // Re-enable: valid only at the second rising edge.
    en     = 1'b1;
    sig_in = 1'b0;
    step();
    step();
    nvalid = 0;
    for (int k = 0; k < 3; k++) begin
      sig_in = (k == 0) ? 1'b1 : 1'b0;
      step();
      if (valid) nvalid++;
    end
    chk("reen_first_edge", nvalid, 0);
    sig_in = 1'b1;
    step();
    chk("reen_valid", int'(valid), 1);
    chk("reen_period", int'(period), 3);
    chk("reen_high", int'(high_time), 1);

    // Reset mid-period clears every output on that edge.
    sig_in = 1'b0;
    step();
    rst_n = 1'b0;
    sig_in = 1'b1;
    step();
    chk("mid_rst_period", int'(period), 0);
    chk("mid_rst_high", int'(high_time), 0);
    chk("mid_rst_valid", int'(valid), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ratio_meter.md
# div_ratio_meter

Measures the period and high time of a divided clock or strobe, in `clk_in` cycles. It is the checking end of the frequency-divider outputs: it takes one divider output (2x, 3x, 4x, …) as `sig_in` and reports the measured divide ratio. It also reports whether the ratio has been stable long enough to call the divider locked. The block is used on-chip for divider self-check and in benches as the divider's monitor.

## Interface
- `CNT_W`, default 8: width of the period/high-time counters; maximum measurable period is 2^CNT_W−1.
- `LOCK_N`, default 4: number of consecutive identical measurements required to assert `locked`.
- `clk_in`  input  1  sole clock; everything samples on its rising edge.
- `rst_n`  input  1  reset, synchronous and active-low.
- `en`  input  1  measurement enable; low forces IDLE.
- `sig_in`  input  1  divided signal, synchronous to `clk_in`, sampled on rising edges only.
- `period`  output  CNT_W  `clk_in` cycles between the last two rising edges of `sig_in`.
- `high_time`  output  CNT_W  number of samples with `sig_in` high in that period.
- `valid`  output  1  one-cycle pulse when `period`/`high_time` update.
- `locked`  output  1  high when the last LOCK_N measurements are identical.
- `overflow`  output  1  sticky; the period exceeded the counter range.

## Operation
- Edge detect: `sig_q` holds the previous sample of `sig_in`. `rise = sig_in & ~sig_q`.
- FSM states: IDLE, WAIT_EDGE, MEASURE.
- IDLE: entered on reset or whenever `en`=0. Counters and the match count are cleared. `valid`=0 and `locked`=0. `period`, `high_time` and `overflow` hold their values. The FSM moves to WAIT_EDGE when `en`=1.
- WAIT_EDGE: on `rise`, set `cnt`←1 and `hi_cnt`←1, then go to MEASURE. No `valid` is produced, because the first edge only opens a window.
- MEASURE, each cycle without `rise`:
  - `cnt`←`cnt`+1.
  - `hi_cnt`←`hi_cnt`+`sig_in`.
- MEASURE, on `rise`:
  - `period`←`cnt` and `high_time`←`hi_cnt`.
  - `valid`←1 and `overflow`←0.
  - `cnt`←1 and `hi_cnt`←1.
- Lock tracking, updated on each `valid`:
  - If the new (`period`, `high_time`) equals the previous pair, `match` increments, saturating at LOCK_N.
  - Otherwise `match`←1.
  - `locked` = (`match` == LOCK_N). `match` is clog2(LOCK_N+1) bits wide.
- Overflow: in MEASURE with `cnt` = 2^CNT_W−1 and no `rise`:
  - `overflow`←1, `locked`←0, `match`←0.
  - The FSM returns to WAIT_EDGE.
  - `sig_in` stuck high or stuck low therefore produces `overflow` and never `valid`.
- Simultaneous events:
  - `en`=0 together with `rise`: `en` wins and no `valid` is produced.
  - `rise` together with `cnt` at maximum: the `rise` wins, giving a valid measurement of period 2^CNT_W−1.
- Reset mid-measurement: with `rst_n`=0 on a clock edge, every register clears on that edge. There is no partial result.

## Timing
- Reset values: `period`=0, `high_time`=0, `valid`=0, `locked`=0, `overflow`=0. The FSM is in IDLE and `sig_q`=0.
- All outputs are registered.
- `valid`, `period`, `high_time` and `locked` update on the clock edge that samples the rising `sig_in` level. They are visible for the following cycle.
- `valid` is high for exactly one cycle per measured rising edge.
- The first `valid` after enable comes at the second rising edge of `sig_in`.
- The earliest `locked` comes at the (LOCK_N+1)-th rising edge.
- `sig_in` must be stable around the rising edge of `clk_in`. Waveforms produced on the falling edge, such as the OR-ed 3x output, are seen only as their rising-edge samples.

## Structure
- Package `div_meter_pkg` holds:
  - the `meter_state_t` enum (IDLE, WAIT_EDGE, MEASURE);
  - default constants `DM_CNT_W`=8 and `DM_LOCK_N`=4.
- Sub-module `rise_det` contains `sig_q` and produces `rise`. It is reused by the other divider monitors.
- Top level: FSM, the two counters, output registers, lock tracker.

## Test plan
- 2x divider: `sig_in` toggles every cycle, enabled from reset release. Required: `valid` every 2 cycles with `period`=2, `high_time`=1; `locked`=1 at the 5th rising edge.
- 4x divider: `sig_in` repeats 1,1,0,0. Required: `period`=4, `high_time`=2; `locked` after 4 identical measurements.
- 3x pattern: `sig_in` repeats 1,1,0. Required: `period`=3, `high_time`=2. Then switch to 1,0,0. Required: `high_time`=1, `locked` drops to 0 on that `valid`, and `match` restarts at 1.
- Overflow: hold `sig_in`=0 for 300 cycles after one rising edge (CNT_W=8). Required: `overflow`=1 at `cnt`=255, `locked`=0, FSM in WAIT_EDGE. After that, two rising edges 4 apart give `valid` with `period`=4 and clear `overflow`.
- Enable and reset:
  - Drop `en` in the same cycle as a `rise`. Required: no `valid`, `locked`=0, `period` unchanged.
  - Re-enable. Required: the first `valid` comes only at the second rising edge.
  - Assert `rst_n`=0 mid-period. Required: all outputs 0 on the next edge.
